debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  Multi-channel debouncer for buttons/switches. Per channel: metastability synchroniser, saturating
//  stability counter, debounced level, one-cycle rise/fall pulses. Sits between raw board inputs and
//  control FSMs; replaces per-pin single debouncers with one parametrised bank. Channels share no state.
// PARAMETERS
//  NUM_CH          4    number of independent input channels (>=1)
//  DEBOUNCE_LIMIT  20   consecutive sampled cycles a new level must persist before acceptance (>=2)
//  SYNC_STAGES     2    flip-flops in each input synchroniser chain (>=2)
//  RESET_STATE     0    level loaded into synchronisers and debounced state on reset (0 or 1, all channels)
// PORTS
//  i_Clk         in   1        system clock; all logic on rising edge
//  i_Rst         in   1        asynchronous, active-high reset
//  i_Bouncy      in   NUM_CH   raw asynchronous inputs, bit n = channel n
//  o_Debounced   out  NUM_CH   debounced level per channel
//  o_Rise        out  NUM_CH   1-cycle pulse when o_Debounced[n] goes 0->1
//  o_Fall        out  NUM_CH   1-cycle pulse when o_Debounced[n] goes 1->0
//  o_Any_Edge    out  1        OR of all o_Rise|o_Fall bits, registered, same cycle as the pulses
// BEHAVIOUR
//  Reset (async assert, sampled deassert by i_Clk):
//   - sync chains and o_Debounced = {NUM_CH{RESET_STATE}}; counters = 0; o_Rise, o_Fall, o_Any_Edge = 0.
//   - reset asserted mid-count discards progress; no edge pulse generated by reset or its release.
//  Synchroniser: SYNC_STAGES-deep shift chain per channel; s[n] = last stage. Only s[n] feeds the counter.
//  Counter: width = $clog2(DEBOUNCE_LIMIT), per channel, unsigned.
//   - s[n] == o_Debounced[n]                           : count <= 0 (any return to old level restarts).
//   - s[n] != o_Debounced[n], count <  DEBOUNCE_LIMIT-1: count <= count+1.
//   - s[n] != o_Debounced[n], count == DEBOUNCE_LIMIT-1: o_Debounced[n] <= s[n]; count <= 0;
//     o_Rise[n] <= s[n]; o_Fall[n] <= ~s[n].
//   - The state update requires s[n] still differing on the accepting edge; never accept a stale level.
//   - Counter never exceeds DEBOUNCE_LIMIT-1; no wrap.
//  Pulses: o_Rise/o_Fall are registered and high exactly the cycle o_Debounced shows the new level;
//   cleared the next cycle. Rise and fall of one channel never coincide. Several channels may pulse
//   in the same cycle; o_Any_Edge is then a single 1-cycle pulse.
//  Latency: new level held for >= DEBOUNCE_LIMIT sampling edges -> o_Debounced changes on edge
//   SYNC_STAGES+DEBOUNCE_LIMIT, counting the first edge that samples the new level as edge 1.
//   Level held for DEBOUNCE_LIMIT-1 edges or fewer -> no output change, no pulse.
//  Steady input: counter stays 0, outputs static. No combinational path from i_Bouncy to any output.
// TESTING  (NUM_CH=4, DEBOUNCE_LIMIT=8, SYNC_STAGES=2, RESET_STATE=0 unless stated)
//  1. Reset, i_Bouncy=4'b0000 then ch0 -> 1 held -> o_Debounced=4'b0001 on edge 10, o_Rise=4'b0001 and
//     o_Any_Edge=1 for that cycle only; o_Fall stays 0.
//  2. ch1 high for 7 edges then low -> o_Debounced[1] stays 0, no pulses; high for exactly 8 -> rises edge 10.
//  3. ch2 pattern 6 high, 1 low, 8 high -> counter restarts at the low sample; o_Debounced[2] rises only
//     SYNC_STAGES+8 edges after the final run begins; single o_Rise pulse.
//  4. ch0 and ch3 change same cycle (0->1, ch3 previously settled 1->0) -> o_Rise=4'b0001, o_Fall=4'b1000
//     in the same cycle; o_Any_Edge one 1-cycle pulse.
//  5. i_Rst asserted asynchronously (between clock edges) with ch1 counter at 5 -> outputs 0 immediately;
//     after release input still high -> full 10-edge latency again, no pulse on release.
//  6. RESET_STATE=1, inputs held 1 through reset -> o_Debounced=4'hF, no pulses; drop ch0 to 0 -> o_Fall[0] on edge 10.

Source files
------------

// File: rtl/debounce_bank.sv
// Multi-channel input debouncer: per-channel synchroniser, saturating stability counter,
// debounced level and registered one-cycle rise/fall pulses.
module debounce_bank #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 20,
    parameter int SYNC_STAGES    = 2,
    parameter int RESET_STATE    = 0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Bouncy,
    output logic [NUM_CH-1:0] o_Debounced,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic              o_Any_Edge
);

    localparam int              CW      = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CW-1:0]   LAST    = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic            RST_LVL = (RESET_STATE != 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
    logic [CW-1:0]                      r_count [NUM_CH];
    logic [NUM_CH-1:0]                  w_sync;
    logic [NUM_CH-1:0]                  w_differ;
    logic [NUM_CH-1:0]                  w_accept;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Acceptance needs the synchronised level to still differ on the accepting edge.
    always_comb begin
        w_differ = w_sync ^ o_Debounced;
        w_accept = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            w_accept[n] = w_differ[n] && (r_count[n] == LAST);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sync      <= {SYNC_STAGES{{NUM_CH{RST_LVL}}}};
            o_Debounced <= {NUM_CH{RST_LVL}};
            o_Rise      <= '0;
            o_Fall      <= '0;
            o_Any_Edge  <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_count[n] <= '0;
            end
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_Bouncy};
            for (int n = 0; n < NUM_CH; n++) begin
                if (!w_differ[n]) begin
                    r_count[n] <= '0;
                end else if (w_accept[n]) begin
                    r_count[n]     <= '0;
                    o_Debounced[n] <= w_sync[n];
                end else begin
                    r_count[n] <= r_count[n] + 1'b1;
                end
            end
            o_Rise     <= w_accept & w_sync;
            o_Fall     <= w_accept & ~w_sync;
            o_Any_Edge <= |w_accept;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: stimulus pushes expected edge events, monitors pop on pulses.
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bouncy_a, bouncy_b;
    logic [3:0] deb_a, rise_a, fall_a, deb_b, rise_b, fall_b;
    logic       any_a, any_b;

    typedef struct {
        int         cyc;
        logic [3:0] deb;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    debounce_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(8), .SYNC_STAGES(2), .RESET_STATE(0)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Bouncy(bouncy_a),
        .o_Debounced(deb_a), .o_Rise(rise_a), .o_Fall(fall_a), .o_Any_Edge(any_a)
    );

    debounce_bank #(.NUM_CH(4), .DEBOUNCE_LIMIT(8), .SYNC_STAGES(2), .RESET_STATE(1)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Bouncy(bouncy_b),
        .o_Debounced(deb_b), .o_Rise(rise_b), .o_Fall(fall_b), .o_Any_Edge(any_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input int c, input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.cyc = c; e.deb = d; e.rise = r; e.fall = f;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int c, input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.cyc = c; e.deb = d; e.rise = r; e.fall = f;
        q_b.push_back(e);
    endtask

    always @(negedge clk) begin
        if (any_a || (rise_a != 4'h0) || (fall_a != 4'h0)) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_edge", {any_a, rise_a, fall_a}, 0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_edge_cycle", cyc, e.cyc);
                check("a_deb", deb_a, e.deb);
                check("a_rise", rise_a, e.rise);
                check("a_fall", fall_a, e.fall);
                check("a_any", any_a, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (any_b || (rise_b != 4'h0) || (fall_b != 4'h0)) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_edge", {any_b, rise_b, fall_b}, 0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_edge_cycle", cyc, e.cyc);
                check("b_deb", deb_b, e.deb);
                check("b_rise", rise_b, e.rise);
                check("b_fall", fall_b, e.fall);
                check("b_any", any_b, 1);
            end
        end
    end

    initial begin
        int c;
        rst      = 1'b1;
        bouncy_a = 4'b0000;
        bouncy_b = 4'b1111;
        wait_edges(3);
        check("rst_deb_a", deb_a, 4'h0);
        check("rst_pulses_a", {any_a, rise_a, fall_a}, 0);
        check("rst_deb_b", deb_b, 4'hF);
        rst = 1'b0;
        wait_edges(12);
        check("steady_deb_a", deb_a, 4'h0);
        check("steady_deb_b", deb_b, 4'hF);

        // 1: ch0 rises after 10 edges
        c = cyc; bouncy_a[0] = 1'b1; push_a(c + 10, 4'b0001, 4'b0001, 4'b0000);
        wait_edges(9);
        check("t1_before", deb_a, 4'b0001 & 4'b0000);
        wait_edges(5);
        check("t1_after", deb_a, 4'b0001);

        // 2: ch1 held 7 edges is rejected, held exactly 8 accepted (then falls again)
        bouncy_a[1] = 1'b1; wait_edges(7); bouncy_a[1] = 1'b0;
        wait_edges(14);
        check("t2_short", deb_a, 4'b0001);
        c = cyc; bouncy_a[1] = 1'b1; push_a(c + 10, 4'b0011, 4'b0010, 4'b0000);
        wait_edges(8); bouncy_a[1] = 1'b0; push_a(c + 18, 4'b0001, 4'b0000, 4'b0010);
        wait_edges(14);
        check("t2_back", deb_a, 4'b0001);

        // 3: ch2 6 high, 1 low, then held high; rise counts from the final run
        c = cyc; bouncy_a[2] = 1'b1;
        wait_edges(6); bouncy_a[2] = 1'b0;
        wait_edges(1); bouncy_a[2] = 1'b1; push_a(c + 17, 4'b0101, 4'b0100, 4'b0000);
        wait_edges(20);
        check("t3_deb", deb_a, 4'b0101);

        // 4: settle ch0=0/ch3=1, then swap in one cycle
        c = cyc; bouncy_a[0] = 1'b0; bouncy_a[3] = 1'b1; push_a(c + 10, 4'b1100, 4'b1000, 4'b0001);
        wait_edges(14);
        c = cyc; bouncy_a[0] = 1'b1; bouncy_a[3] = 1'b0; push_a(c + 10, 4'b0101, 4'b0001, 4'b1000);
        wait_edges(14);
        check("t4_deb", deb_a, 4'b0101);

        // 5: async reset with ch1 counter at 5; full latency after release
        bouncy_a[1] = 1'b1;
        wait_edges(7);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_deb", deb_a, 4'h0);
        check("t5_rst_pulses", {any_a, rise_a, fall_a}, 0);
        check("t5_rst_deb_b", deb_b, 4'hF);
        wait_edges(2);
        c = cyc; rst = 1'b0; push_a(c + 10, 4'b0111, 4'b0111, 4'b0000);
        wait_edges(9);
        check("t5_before", deb_a, 4'h0);
        wait_edges(3);
        check("t5_after", deb_a, 4'b0111);

        // 6: RESET_STATE=1 instance, drop ch0
        check("t6_init", deb_b, 4'hF);
        c = cyc; bouncy_b[0] = 1'b0; push_b(c + 10, 4'b1110, 4'b0000, 4'b0001);
        wait_edges(14);
        check("t6_deb", deb_b, 4'hE);

        check("q_a_left", q_a.size(), 0);
        check("q_b_left", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
